// File: rtl/block_sync_pkg.sv
// block_sync_pkg: 64b/66b sync header codes, aligner FSM state type
// and the header validity check shared by the block aligner files.
package block_sync_pkg;

    localparam logic [1:0] c_DATA_HEADER = 2'b01;
    localparam logic [1:0] c_CMD_HEADER  = 2'b10;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } sync_state_e;

    function automatic logic hdr_good(input logic [1:0] hdr);
        return (hdr == c_DATA_HEADER) || (hdr == c_CMD_HEADER);
    endfunction

endpackage

// File: rtl/hdr_argmax.sv
// hdr_argmax: 2-stage registered argmax over N candidate counters.
// Ports: clk_i/rst_ni clock and async reset, flush drops in-flight
// results, in_vld/cnt candidate vector, out_vld/best_off/best_cnt result.
module hdr_argmax
    import block_sync_pkg::*;
#(
    parameter int N     = 66,
    parameter int CNT_W = 6,
    parameter int GRP   = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush,
    input  logic                    in_vld,
    input  logic [N-1:0][CNT_W-1:0] cnt,
    output logic                    out_vld,
    output logic [$clog2(N)-1:0]    best_off,
    output logic [CNT_W-1:0]        best_cnt
);

    localparam int IDX_W = $clog2(N);
    localparam int NG    = (N + GRP - 1) / GRP;

    logic [NG*GRP-1:0][CNT_W-1:0] cnt_pad;
    logic [NG-1:0][CNT_W-1:0]     g_cnt;
    logic [NG-1:0][IDX_W-1:0]     g_idx;
    logic [NG-1:0][CNT_W-1:0]     s1_cnt;
    logic [NG-1:0][IDX_W-1:0]     s1_idx;
    logic                         s1_vld;
    logic [CNT_W-1:0]             m_cnt;
    logic [IDX_W-1:0]             m_idx;

    // Padding entries are zero, so a strict > never picks them.
    always_comb begin
        cnt_pad        = '0;
        cnt_pad[N-1:0] = cnt;
    end

    // Strict > with ascending scan keeps the lowest index on ties.
    always_comb begin
        for (int g = 0; g < NG; g++) begin
            g_cnt[g] = cnt_pad[g*GRP];
            g_idx[g] = IDX_W'(g*GRP);
            for (int j = 1; j < GRP; j++) begin
                if (cnt_pad[g*GRP+j] > g_cnt[g]) begin
                    g_cnt[g] = cnt_pad[g*GRP+j];
                    g_idx[g] = IDX_W'(g*GRP+j);
                end
            end
        end
    end

    always_comb begin
        m_cnt = s1_cnt[0];
        m_idx = s1_idx[0];
        for (int g = 1; g < NG; g++) begin
            if (s1_cnt[g] > m_cnt) begin
                m_cnt = s1_cnt[g];
                m_idx = s1_idx[g];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_vld   <= 1'b0;
            s1_cnt   <= '0;
            s1_idx   <= '0;
            out_vld  <= 1'b0;
            best_cnt <= '0;
            best_off <= '0;
        end else begin
            s1_vld  <= in_vld & ~flush;
            out_vld <= s1_vld & ~flush;
            if (in_vld) begin
                s1_cnt <= g_cnt;
                s1_idx <= g_idx;
            end
            if (s1_vld) begin
                best_cnt <= m_cnt;
                best_off <= m_idx;
            end
        end
    end

endmodule

// File: rtl/block_sync_lock.sv
// block_sync_lock: 64b/66b block aligner with HUNT/LOCKED hysteresis.
// Ports: clk_i/rst_ni, gbox_buffer/gbox_cnt/buffer_dv in; block_offset,
// offset_vld, locked, hdr_err pulse and lock_lost pulse out.
module block_sync_lock
    import block_sync_pkg::*;
#(
    parameter int BUF_W    = 194,
    parameter int BLK_W    = 66,
    parameter int CNT_W    = 6,
    parameter int LOCK_CNT = 32,
    parameter int ERR_WIN  = 64,
    parameter int ERR_MAX  = 16,
    parameter int GRP      = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [BUF_W-1:0]               gbox_buffer,
    input  logic [$clog2(BUF_W-BLK_W)-1:0] gbox_cnt,
    input  logic                           buffer_dv,
    output logic [$clog2(BLK_W)-1:0]       block_offset,
    output logic                           offset_vld,
    output logic                           locked,
    output logic                           hdr_err,
    output logic                           lock_lost
);

    localparam int OFF_W = $clog2(BLK_W);
    localparam int SEL_W = $clog2(BUF_W);
    localparam int ERR_W = $clog2(ERR_MAX + 1);
    localparam int WIN_W = $clog2(ERR_WIN);

    localparam logic [CNT_W-1:0] CNT_SAT  = '1;
    localparam logic [CNT_W-1:0] LOCK_TH  = CNT_W'(LOCK_CNT);
    localparam logic [ERR_W-1:0] ERR_LAST = ERR_W'(ERR_MAX - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(ERR_WIN - 1);

    logic [SEL_W-1:0]            sel_top;
    logic [BLK_W:0]              win_q;
    logic                        win_vld_q;
    logic [BLK_W-1:0]            good;
    logic [BLK_W-1:0][CNT_W-1:0] cnt_q;
    logic                        cnt_vld_q;
    logic [BLK_W-1:0]            good_c_q;
    logic [BLK_W-1:0]            good_s1_q;
    logic [BLK_W-1:0]            good_s2_q;
    logic                        gv1_q;
    logic                        am_vld;
    logic [OFF_W-1:0]            am_off;
    logic [CNT_W-1:0]            am_cnt;
    logic                        flush;
    logic                        bad;

    sync_state_e                 state_q, state_d;
    logic [OFF_W-1:0]            lock_off_q, off_d;
    logic [ERR_W-1:0]            err_cnt_q, err_d;
    logic [WIN_W-1:0]            blk_cnt_q, blk_d;
    logic                        herr_d;
    logic                        lost_d;

    assign sel_top = SEL_W'(BUF_W - 1) - SEL_W'(gbox_cnt);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            win_q     <= '0;
            win_vld_q <= 1'b0;
        end else begin
            win_vld_q <= buffer_dv;
            if (buffer_dv) begin
                win_q <= gbox_buffer[sel_top -: BLK_W+1];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < BLK_W; i++) begin
            good[i] = hdr_good(win_q[i+1 -: 2]);
        end
    end

    // The good vector travels alongside the argmax so the FSM checks
    // the header of the same block whose score it is looking at.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            cnt_vld_q <= 1'b0;
            good_c_q  <= '0;
            gv1_q     <= 1'b0;
            good_s1_q <= '0;
            good_s2_q <= '0;
        end else begin
            cnt_vld_q <= win_vld_q & ~flush;
            gv1_q     <= cnt_vld_q & ~flush;
            if (flush) begin
                cnt_q <= '0;
            end else if (win_vld_q) begin
                for (int i = 0; i < BLK_W; i++) begin
                    if (!good[i]) begin
                        cnt_q[i] <= '0;
                    end else if (cnt_q[i] != CNT_SAT) begin
                        cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                    end
                end
            end
            if (win_vld_q) good_c_q  <= good;
            if (cnt_vld_q) good_s1_q <= good_c_q;
            if (gv1_q)     good_s2_q <= good_s1_q;
        end
    end

    hdr_argmax #(
        .N     (BLK_W),
        .CNT_W (CNT_W),
        .GRP   (GRP)
    ) u_argmax (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .flush    (flush),
        .in_vld   (cnt_vld_q),
        .cnt      (cnt_q),
        .out_vld  (am_vld),
        .best_off (am_off),
        .best_cnt (am_cnt)
    );

    assign bad   = ~good_s2_q[lock_off_q];
    assign flush = lost_d;

    // While locked the argmax result is ignored: that is the hysteresis.
    // Unlock takes priority over the end-of-window clear.
    always_comb begin
        state_d = state_q;
        off_d   = lock_off_q;
        err_d   = err_cnt_q;
        blk_d   = blk_cnt_q;
        herr_d  = 1'b0;
        lost_d  = 1'b0;
        if (am_vld) begin
            unique case (state_q)
                HUNT: begin
                    if (am_cnt >= LOCK_TH) begin
                        state_d = LOCKED;
                        off_d   = am_off;
                        err_d   = '0;
                        blk_d   = '0;
                    end
                end
                LOCKED: begin
                    herr_d = bad;
                    if (bad && (err_cnt_q == ERR_LAST)) begin
                        state_d = HUNT;
                        lost_d  = 1'b1;
                        err_d   = '0;
                        blk_d   = '0;
                    end else if (blk_cnt_q == WIN_LAST) begin
                        err_d = '0;
                        blk_d = '0;
                    end else begin
                        err_d = err_cnt_q + ERR_W'(bad);
                        blk_d = blk_cnt_q + WIN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= HUNT;
            lock_off_q   <= '0;
            err_cnt_q    <= '0;
            blk_cnt_q    <= '0;
            locked       <= 1'b0;
            offset_vld   <= 1'b0;
            block_offset <= '0;
            hdr_err      <= 1'b0;
            lock_lost    <= 1'b0;
        end else begin
            state_q      <= state_d;
            lock_off_q   <= off_d;
            err_cnt_q    <= err_d;
            blk_cnt_q    <= blk_d;
            locked       <= (state_d == LOCKED);
            offset_vld   <= (state_d == LOCKED);
            block_offset <= (state_d == LOCKED) ? off_d : '0;
            hdr_err      <= herr_d;
            lock_lost    <= lost_d;
        end
    end

    a_gbox_cnt_range: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        buffer_dv |-> (int'(gbox_cnt) <= BUF_W - BLK_W - 1)
    );

endmodule

// File: tb/tb_block_sync_lock.sv
// tb_block_sync_lock: directed scoreboard bench for block_sync_lock.
// Each issued block queues its expected outputs; a monitor checks them.
module tb_block_sync_lock;

    localparam int BUF_W = 194;
    localparam int BLK_W = 66;
    localparam int OFF_W = 7;
    localparam int GC_W  = 7;

    typedef struct packed {
        int               id;
        logic             lk;
        logic [OFF_W-1:0] off;
        logic             he;
        logic             ll;
    } exp_t;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic [BUF_W-1:0] gbox_buffer;
    logic [GC_W-1:0]  gbox_cnt;
    logic             buffer_dv;
    logic [OFF_W-1:0] block_offset;
    logic             offset_vld;
    logic             locked;
    logic             hdr_err;
    logic             lock_lost;

    exp_t       sbq[$];
    int         n_chk = 0;
    int         n_err = 0;
    logic [4:0] dvh = '0;

    always #5 clk_i = ~clk_i;

    block_sync_lock dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .gbox_buffer  (gbox_buffer),
        .gbox_cnt     (gbox_cnt),
        .buffer_dv    (buffer_dv),
        .block_offset (block_offset),
        .offset_vld   (offset_vld),
        .locked       (locked),
        .hdr_err      (hdr_err),
        .lock_lost    (lock_lost)
    );

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    function automatic int outs();
        return int'({locked, offset_vld, block_offset, hdr_err, lock_lost});
    endfunction

    // One-hot window: header 01 on even blocks, 10 on odd blocks.
    function automatic logic [BLK_W:0] mkwin(input int o, input int k);
        logic [BLK_W:0] w;
        w = '0;
        w[o + (k % 2)] = 1'b1;
        return w;
    endfunction

    task automatic send(input logic [BLK_W:0] w, input int g,
                        input int id, input logic lk, input int off,
                        input logic he, input logic ll);
        logic [BUF_W-1:0] b, wx, msk;
        exp_t e;
        int sh;
        for (int i = 0; i < BUF_W; i++) b[i] = 1'($urandom_range(0, 1));
        wx = '0;
        wx[BLK_W:0] = w;
        msk = '0;
        msk[BLK_W:0] = '1;
        sh = (BUF_W - BLK_W - 1) - g;
        b = (b & ~(msk << sh)) | (wx << sh);
        e.id  = id;
        e.lk  = lk;
        e.off = lk ? OFF_W'(off) : '0;
        e.he  = he;
        e.ll  = ll;
        gbox_buffer = b;
        gbox_cnt    = GC_W'(g);
        buffer_dv   = 1'b1;
        sbq.push_back(e);
        @(posedge clk_i);
        #1;
        buffer_dv = 1'b0;
    endtask

    task automatic drain();
        repeat (8) @(posedge clk_i);
        #2;
        chk("sb_drained", sbq.size(), 0);
    endtask

    task automatic do_reset();
        drain();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        chk("reset_outputs", outs(), 0);
        sbq.delete();
    endtask

    initial begin
        exp_t e;
        logic [10:0] got, req;
        forever begin
            @(posedge clk_i);
            dvh = rst_ni ? {dvh[3:0], buffer_dv} : '0;
            #1;
            if (dvh[4]) begin
                n_chk++;
                if (sbq.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_pop: output with no queued entry");
                end else begin
                    e   = sbq.pop_front();
                    got = {locked, offset_vld, block_offset,
                           hdr_err, lock_lost};
                    req = {e.lk, e.lk, e.off, e.he, e.ll};
                    if (got !== req) begin
                        n_err++;
                        $display("FAIL blk%0d lk/vld/off/herr/lost: got %0d/%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d/%0d",
                                 e.id, got[10], got[9], got[8:2],
                                 got[1], got[0], req[10], req[9],
                                 req[8:2], req[1], req[0]);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        buffer_dv   = 1'b0;
        gbox_buffer = '0;
        gbox_cnt    = '0;
        do_reset();

        // Aligned stream at 17: lock at block 31 (36 cycles after first dv).
        for (int k = 0; k < 40; k++)
            send(mkwin(17, k), 0, 1000 + k, k >= 31, 17, 1'b0, 1'b0);
        do_reset();

        // Tie between 5 and 40: lowest index wins.
        for (int k = 0; k < 40; k++)
            send(mkwin(5, k) | mkwin(40, k), 0, 2000 + k,
                 k >= 31, 5, 1'b0, 1'b0);
        do_reset();

        // 15 errors hold lock, 16th drops it; cleared counters relock
        // only after 32 blocks past the flushed ones (block 95).
        for (int k = 0; k <= 100; k++) begin
            logic bd;
            bd = (k >= 40 && k <= 54) || (k == 60);
            if (k < 60)
                send(bd ? '0 : mkwin(17, k), 0, 3000 + k,
                     k >= 31, 17, bd, 1'b0);
            else if (k == 60)
                send('0, 0, 3000 + k, 1'b0, 0, 1'b1, 1'b1);
            else
                send(mkwin(17, k), 0, 3000 + k, k >= 95, 17, 1'b0, 1'b0);
        end
        do_reset();

        // 15 errors at the end of window 1, 15 at the start of window 2.
        for (int k = 0; k <= 170; k++) begin
            logic bd;
            bd = (k >= 81 && k <= 110);
            send(bd ? '0 : mkwin(17, k), 0, 4000 + k,
                 k >= 31, 17, bd, 1'b0);
        end
        do_reset();

        // Stream moves from 17 to 30: unlock at 16th error, relock at 30.
        for (int k = 0; k <= 90; k++) begin
            if (k <= 31)
                send(mkwin(17, k), 0, 5000 + k, k >= 31, 17, 1'b0, 1'b0);
            else if (k < 47)
                send(mkwin(30, k), 0, 5000 + k, 1'b1, 17, 1'b1, 1'b0);
            else if (k == 47)
                send(mkwin(30, k), 0, 5000 + k, 1'b0, 0, 1'b1, 1'b1);
            else
                send(mkwin(30, k), 0, 5000 + k, k >= 82, 30, 1'b0, 1'b0);
        end
        do_reset();

        // Short async reset while locked, away from any clock edge.
        for (int k = 0; k < 40; k++)
            send(mkwin(17, k), 0, 6000 + k, k >= 31, 17, 1'b0, 1'b0);
        drain();
        @(posedge clk_i);
        #3;
        chk("pre_reset_locked", int'(locked), 1);
        rst_ni = 1'b0;
        #1;
        chk("async_reset_outputs", outs(), 0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        chk("post_reset_no_lost", int'(lock_lost), 0);
        for (int k = 0; k < 40; k++)
            send(mkwin(17, k), 0, 6100 + k, k >= 31, 17, 1'b0, 1'b0);
        do_reset();

        // gbox_cnt sweep with random gaps; counter saturates at 63.
        for (int k = 0; k < 128; k++) begin
            send(mkwin(17, k), k, 7000 + k, k >= 31, 17, 1'b0, 1'b0);
            n = $urandom_range(0, 2);
            if (n > 0) begin
                repeat (n) @(posedge clk_i);
                #1;
            end
        end
        drain();
        chk("cnt17_saturated", int'(dut.cnt_q[17]), 63);
        chk("sweep_offset", int'(block_offset), 17);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
